i2c_slave: RTL
==============

Name: i2c_slave

Overview:
- I2C target (responder) that sits on the same open-drain SCL/SDA pair driven by the team's I2C master.
- Runs fully on the system clock; SCL/SDA are oversampled, synchronised and glitch-filtered.
- Decodes START/STOP, matches a 7-bit address, takes a register pointer byte, then performs byte writes or reads to an external register bank with pointer auto-increment.
- Used as a loopback/bring-up target and as the I2C end of on-board peripherals.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this target ACKs.
- FILTER_LEN, 4, clk cycles a synchronised line level must hold stable before it is accepted.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_scl  in  1  SCL pad level.
- i_sda  in  1  SDA pad level.
- o_sda  out  1  0 = pull SDA low; 1 = release (top level converts to 1'bz).
- o_reg_addr  out  8  current register pointer.
- i_rd_data  in  8  register contents at o_reg_addr; must be valid within 1 clk of o_reg_addr changing.
- o_wr_data  out  8  byte received from the master.
- o_wr_stb  out  1  one-cycle pulse; write o_wr_data to o_reg_addr.
- o_busy  out  1  high from an addressed START/ACK until STOP.

Behaviour:
- Reset values: o_sda=1, o_reg_addr=0, o_wr_data=0, o_wr_stb=0, o_busy=0, FSM=IDLE, filters preset to 1.
- Reset mid-transfer: SDA is released immediately and the FSM ignores the bus until the next START.
- Input conditioning:
  - 2-FF synchroniser, then a filter: filtered level changes only after FILTER_LEN consecutive equal samples.
  - Edge flags scl_rise, scl_fall, sda_rise, sda_fall are single-cycle pulses of the filtered levels.
- Bus conditions:
  - START = sda_fall while filtered SCL=1.
  - STOP = sda_rise while filtered SCL=1.
  - START in any state (repeated START) goes to ADDR and clears the bit counter.
  - STOP in any state goes to IDLE, releases SDA and clears o_busy.
  - START/STOP take priority over data bits in the same cycle.
- Data timing:
  - Bits are sampled on scl_rise, MSB first.
  - The target changes o_sda only on the cycle after scl_fall.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- ADDR:
  - After 8 bits, compare bits[7:1] with SLAVE_ADDR.
  - Match → ADDR_ACK: drive SDA=0 for the 9th clock and set o_busy.
  - Mismatch → WAIT_STOP with no ACK.
  - A match with R/W=1 loads i_rd_data into the shift register when the ACK bit's SCL falls, then → RD_DATA.
  - A match with R/W=0 → PTR.
- PTR: after 8 bits, o_reg_addr ← byte, ACK, → WR_DATA.
- WR_DATA:
  - After 8 bits, o_wr_data ← byte and o_wr_stb pulses for one clk in the cycle after the 8th scl_rise.
  - o_reg_addr increments on the following clk (8-bit wrap, 8'hFF→8'h00), then ACK via WR_ACK → WR_DATA.
- RD_DATA:
  - Shift the MSB out on each post-scl_fall cycle; release SDA after the 8th bit.
  - o_reg_addr increments after the byte is loaded.
- RD_ACK: sample master ACK on scl_rise.
  - ACK (0) → reload i_rd_data and → RD_DATA.
  - NACK (1) → WAIT_STOP, SDA released.
- WAIT_STOP: SDA released; leave only on STOP or START.
- Lost bits or extra edges never make the target drive SDA outside ACK/RD_DATA.

Optional Feature:
- Macro: I2C_SLAVE_GENCALL_EN.
- Defined: address byte 8'h00 (general call) is ACKed. The next byte is treated as data and written with o_wr_stb to o_reg_addr=8'h00, with no pointer phase.
- Undefined: 8'h00 is an ordinary mismatch and is NACKed.

Decomposition:
- Package i2c_pkg holds:
  - the FSM state encoding;
  - the I2C_GENCALL_ADDR=7'h00 and I2C_RW_READ=1'b1 constants.
- Natural sub-module: i2c_line_filter (synchroniser + FILTER_LEN debounce + rise/fall pulses), instantiated for SCL and SDA.

Test Plan:
- Write: START, 0xA0, 0x10, 0x5A, STOP.
  - Expect ACK on all 3 bytes.
  - o_wr_stb once with o_reg_addr=0x10, o_wr_data=0x5A; o_reg_addr=0x11 afterwards.
- Read with repeated START: 0xA0, 0x20, rSTART, 0xA1, master ACK then NACK, STOP.
  - Bank returns ~addr, so the master receives 0xDF then 0xDE; o_busy falls at STOP.
- Address mismatch: 0xA4 (7'h52).
  - SDA never driven low; no o_wr_stb; traffic ignored until the next START.
- Wrap: pointer 0xFF, write 0x11, 0x22.
  - Strobes at addresses 0xFF then 0x00.
- Filter: a SDA low pulse of FILTER_LEN-1 clks while SCL=1 causes no START; a pulse of FILTER_LEN clks causes START.
- Reset asserted during RD_DATA with o_sda=0.
  - o_sda=1 the next clk; FSM ignores the bus until the next START; with I2C_SLAVE_GENCALL_EN, 0x00, 0x77 → strobe at addr 0x00, data 0x77.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM encoding and bus constants for the I2C target.
// Imported by i2c_slave.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_state_e;

  localparam logic [6:0] I2C_GENCALL_ADDR = 7'h00;
  localparam logic       I2C_RW_READ      = 1'b1;

endpackage

// File: rtl/i2c_slave_if.sv
// i2c_slave_if: pad levels plus register-bank port of the I2C target.
// slave modport for the target, master modport for the bus/bank side.
interface i2c_slave_if;
  logic       i_scl;
  logic       i_sda;
  logic       o_sda;
  logic [7:0] o_reg_addr;
  logic [7:0] i_rd_data;
  logic [7:0] o_wr_data;
  logic       o_wr_stb;
  logic       o_busy;

  modport slave (
    input  i_scl, i_sda, i_rd_data,
    output o_sda, o_reg_addr, o_wr_data,
    output o_wr_stb, o_busy
  );

  modport master (
    output i_scl, i_sda, i_rd_data,
    input  o_sda, o_reg_addr, o_wr_data,
    input  o_wr_stb, o_busy
  );
endinterface

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-FF synchroniser, FILTER_LEN debounce and
// single-cycle rise/fall pulses of the filtered level.
module i2c_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN) + 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // accept a new level only after FILTER_LEN equal samples
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], pad};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        rise  <= sync[1];
        fall  <= ~sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with pointer byte and auto-increment bank access.
// Define I2C_SLAVE_GENCALL_EN to ACK general call (8'h00) as a write to 0.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILTER_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  i2c_slave_if.slave  bus
);
  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;
  logic start, stop, sda_upd;

  i2c_state_e state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sh, sh_n;
  logic [7:0] addr_q, addr_n;
  logic [7:0] wdata, wdata_n;
  logic [7:0] byte_in;
  logic       sda_q, sda_n;
  logic       stb, stb_n;
  logic       busy, busy_n;
  logic       inc, inc_n;
  logic       rw, rw_n;
  logic       gc, gc_n;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk   (clk),
    .reset (reset),
    .pad   (bus.i_scl),
    .level (scl_f),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk   (clk),
    .reset (reset),
    .pad   (bus.i_sda),
    .level (sda_f),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  assign start   = sda_fall & scl_f;
  assign stop    = sda_rise & scl_f;
  assign byte_in = {sh[6:0], sda_f};

  assign bus.o_sda      = sda_q;
  assign bus.o_reg_addr = addr_q;
  assign bus.o_wr_data  = wdata;
  assign bus.o_wr_stb   = stb;
  assign bus.o_busy     = busy;

  // state and datapath registers; SDA released on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      addr_q  <= '0;
      wdata   <= '0;
      sda_q   <= 1'b1;
      stb     <= 1'b0;
      busy    <= 1'b0;
      inc     <= 1'b0;
      rw      <= 1'b0;
      gc      <= 1'b0;
      sda_upd <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sh      <= sh_n;
      addr_q  <= addr_n;
      wdata   <= wdata_n;
      sda_q   <= sda_n;
      stb     <= stb_n;
      busy    <= busy_n;
      inc     <= inc_n;
      rw      <= rw_n;
      gc      <= gc_n;
      sda_upd <= scl_fall;
    end
  end

  // next state; bus conditions override bit handling
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    addr_n  = addr_q;
    wdata_n = wdata;
    sda_n   = sda_q;
    stb_n   = 1'b0;
    busy_n  = busy;
    inc_n   = 1'b0;
    rw_n    = rw;
    gc_n    = gc;

    if (inc) addr_n = addr_q + 8'd1;

    if (start) begin
      state_n = ADDR;
      cnt_n   = '0;
      sda_n   = 1'b1;
      gc_n    = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      cnt_n   = '0;
      sda_n   = 1'b1;
      busy_n  = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          sh_n  = byte_in;
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            if (byte_in[7:1] == SLAVE_ADDR) begin
              state_n = ADDR_ACK;
              busy_n  = 1'b1;
              rw_n    = (byte_in[0] == I2C_RW_READ);
`ifdef I2C_SLAVE_GENCALL_EN
            end else if (byte_in == {I2C_GENCALL_ADDR, 1'b0}) begin
              state_n = ADDR_ACK;
              busy_n  = 1'b1;
              rw_n    = 1'b0;
              gc_n    = 1'b1;
`endif
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: if (sda_upd) begin
          if (sda_q) begin
            sda_n = 1'b0;
          end else if (rw) begin
            sh_n    = bus.i_rd_data;
            sda_n   = bus.i_rd_data[7];
            cnt_n   = 4'd1;
            inc_n   = 1'b1;
            state_n = RD_DATA;
          end else begin
            sda_n = 1'b1;
            cnt_n = '0;
            if (gc) begin
              state_n = WR_DATA;
              addr_n  = 8'h00;
            end else begin
              state_n = PTR;
            end
          end
        end
        PTR: if (scl_rise) begin
          sh_n  = byte_in;
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            addr_n  = byte_in;
            state_n = PTR_ACK;
          end
        end
        WR_DATA: if (scl_rise) begin
          sh_n  = byte_in;
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            wdata_n = byte_in;
            stb_n   = 1'b1;
            inc_n   = 1'b1;
            state_n = WR_ACK;
          end
        end
        PTR_ACK, WR_ACK: if (sda_upd) begin
          if (sda_q) begin
            sda_n = 1'b0;
          end else begin
            sda_n   = 1'b1;
            cnt_n   = '0;
            state_n = WR_DATA;
          end
        end
        RD_DATA: if (sda_upd) begin
          if (cnt == 4'd0) begin
            sh_n  = bus.i_rd_data;
            sda_n = bus.i_rd_data[7];
            cnt_n = 4'd1;
            inc_n = 1'b1;
          end else if (cnt == 4'd8) begin
            sda_n   = 1'b1;
            state_n = RD_ACK;
          end else begin
            sda_n = sh[6];
            sh_n  = {sh[6:0], 1'b0};
            cnt_n = cnt + 4'd1;
          end
        end
        RD_ACK: if (scl_rise) begin
          if (sda_f) begin
            state_n = WAIT_STOP;
          end else begin
            state_n = RD_DATA;
            cnt_n   = '0;
          end
        end
        default: sda_n = 1'b1;
      endcase
    end
  end
endmodule
